exp4_gravador_sequencia: RTL

- Writer side of the memory-game datapath: records a player-entered sequence of switch values into an internal RAM, one entry per `jogada` press.
- The downstream checker datapath later reads the entries back through a synchronous read port.
- Contains its own control FSM, address counter, input register, press edge detector and a dual-port RAM.

---
 rtl/exp4_gravador_sequencia_pkg.sv | 18 +
 rtl/exp4_gravador_sequencia_sync_ram_dp.sv | 39 +++
 rtl/exp4_gravador_sequencia.sv | 106 ++++++++++
 3 files changed

// File: rtl/exp4_gravador_sequencia_pkg.sv
// Shared state codes and default widths for the memory-game recorder and checker.
package exp4_gravador_sequencia_pkg;

    localparam int unsigned ADDR_W_DEF = 4;
    localparam int unsigned DATA_W_DEF = 4;
    localparam int unsigned ESTADO_W   = 4;

    typedef enum logic [ESTADO_W-1:0] {
        INICIAL  = 4'd0,
        PREPARA  = 4'd1,
        ESPERA   = 4'd2,
        REGISTRA = 4'd3,
        ESCREVE  = 4'd4,
        PROXIMO  = 4'd5,
        FIM      = 4'd6
    } estado_t;

endpackage

// File: rtl/exp4_gravador_sequencia_sync_ram_dp.sv
// Dual-port RAM: one synchronous write port, one registered read-before-write read port.
module sync_ram_dp
    import exp4_gravador_sequencia_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    localparam int unsigned WORDS = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [WORDS];
    logic [DATA_W-1:0] r_rd_data;

    // Array deliberately has no reset; contents survive a controller reset.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/exp4_gravador_sequencia.sv
// Sequence recorder: stores one switch value per press into RAM, readable by the checker.
module exp4_gravador_sequencia
    import exp4_gravador_sequencia_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                iniciar,
    input  logic [DATA_W-1:0]   chaves,
    input  logic                jogada,
    input  logic [ADDR_W-1:0]   rd_endereco,
    output logic [DATA_W-1:0]   rd_dado,
    output logic                gravando,
    output logic                pronto,
    output logic [ADDR_W-1:0]   db_endereco,
    output logic [DATA_W-1:0]   db_chaves,
    output logic [ESTADO_W-1:0] db_estado
);

    localparam logic [ADDR_W-1:0] ULTIMO = ADDR_W'(DEPTH - 1);

    estado_t           r_estado;
    estado_t           w_prox;
    logic [ADDR_W-1:0] r_endereco;
    logic [DATA_W-1:0] r_chaves;
    logic              r_jogada_d;
    logic              r_gravando;
    logic              r_pronto;
    logic              w_borda;
    logic              w_we;

    assign w_borda = jogada & ~r_jogada_d;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_estado <= INICIAL;
        end else begin
            r_estado <= w_prox;
        end
    end

    always_comb begin
        w_prox = INICIAL;
        w_we   = 1'b0;
        case (r_estado)
            INICIAL:  w_prox = iniciar ? PREPARA : INICIAL;
            PREPARA:  w_prox = ESPERA;
            ESPERA:   w_prox = w_borda ? REGISTRA : ESPERA;
            REGISTRA: w_prox = ESCREVE;
            ESCREVE: begin
                w_we   = 1'b1;
                w_prox = (r_endereco == ULTIMO) ? FIM : PROXIMO;
            end
            PROXIMO:  w_prox = ESPERA;
            FIM:      w_prox = iniciar ? PREPARA : FIM;
            default:  w_prox = INICIAL;
        endcase
    end

    // Status flags are registered from the next state so they line up with r_estado.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_endereco <= '0;
            r_chaves   <= '0;
            r_jogada_d <= 1'b0;
            r_gravando <= 1'b0;
            r_pronto   <= 1'b0;
        end else begin
            r_jogada_d <= jogada;
            r_gravando <= (w_prox == ESPERA);
            r_pronto   <= (w_prox == FIM);
            case (r_estado)
                PREPARA: begin
                    r_endereco <= '0;
                    r_chaves   <= '0;
                end
                REGISTRA: r_chaves   <= chaves;
                PROXIMO:  r_endereco <= r_endereco + ADDR_W'(1);
                default: ;
            endcase
        end
    end

    sync_ram_dp #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .i_clk     (clock),
        .i_rst_n   (reset),
        .i_we      (w_we),
        .i_wr_addr (r_endereco),
        .i_wr_data (r_chaves),
        .i_rd_addr (rd_endereco),
        .o_rd_data (rd_dado)
    );

    assign gravando    = r_gravando;
    assign pronto      = r_pronto;
    assign db_endereco = r_endereco;
    assign db_chaves   = r_chaves;
    assign db_estado   = r_estado;

endmodule
